// File: rtl/instr_encoder.sv
// MIPS instruction encoder that streams encoded words into instruction memory.
// One write per accepted legal beat, one cycle after acceptance.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              full,
  output logic              err_op
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FULL,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST  = '1;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_err;

  logic                w_acc;
  logic                w_legal;
  logic                w_wr;
  logic                w_start;
  logic [ADDR_W:0]     w_cnt_nx;
  logic [31:0]         w_enc;

  assign in_ready = (r_state == S_LOAD);
  assign w_acc    = in_valid & in_ready;
  assign w_legal  = ~op_sel[3];
  assign w_wr     = w_acc & w_legal;
  assign w_start  = start &
                    ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_cnt_nx = r_count + {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    w_enc = '0;
    case (op_sel)
      4'd0: w_enc = {6'b000000, rs, rt, rd, shamt, funct};
      4'd1: w_enc = {6'b100011, rs, rt, imm};
      4'd2: w_enc = {6'b101011, rs, rt, imm};
      4'd3: w_enc = {6'b000100, rs, rt, imm};
      4'd4: w_enc = {6'b000101, rs, rt, imm};
      4'd5: w_enc = {6'b000010, target};
      4'd6: w_enc = {6'b001000, rs, rt, imm};
      4'd7: w_enc = {6'b001100, rs, rt, imm};
      default: w_enc = '0;
    endcase
  end

  // done takes priority over the full transition on the last beat
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: begin
        if (done) w_next = S_DONE;
        else if (w_wr && (w_cnt_nx == DEPTH)) w_next = S_FULL;
      end
      S_FULL: if (done) w_next = S_DONE;
      S_DONE: if (start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_we    <= w_wr;
      if (w_start) begin
        r_ptr   <= '0;
        r_count <= '0;
        r_addr  <= '0;
        r_err   <= 1'b0;
      end else if (w_wr) begin
        r_addr  <= r_ptr;
        r_wdata <= w_enc;
        r_count <= w_cnt_nx;
        if (r_ptr != LAST) r_ptr <= r_ptr + ADDR_W'(1);
      end else if (w_acc) begin
        r_err <= 1'b1;
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign count      = r_count;
  assign busy       = (r_state == S_LOAD) | (r_state == S_FULL);
  assign full       = (r_state == S_FULL);
  assign err_op     = r_err;

endmodule
